// File: rtl/fpa_pkg.sv
// Shared types and constants for the double-precision adder self-test sequencer.
package fpa_pkg;

   localparam int DP_WIDTH = 64;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // Field MSBs within a {a, b, expected} vector word at DP_WIDTH.
   localparam int A_MSB   = 3*DP_WIDTH - 1;
   localparam int B_MSB   = 2*DP_WIDTH - 1;
   localparam int EXP_MSB = DP_WIDTH - 1;

   localparam logic [DP_WIDTH-1:0] DP_1   = 64'h3FF0000000000000;
   localparam logic [DP_WIDTH-1:0] DP_2   = 64'h4000000000000000;
   localparam logic [DP_WIDTH-1:0] DP_20  = 64'h4034000000000000;
   localparam logic [DP_WIDTH-1:0] DP_50  = 64'h4049000000000000;
   localparam logic [DP_WIDTH-1:0] DP_70  = 64'h4051800000000000;
   localparam logic [DP_WIDTH-1:0] DP_90  = 64'h4056800000000000;
   localparam logic [DP_WIDTH-1:0] DP_180 = 64'h4066800000000000;

endpackage

// File: rtl/fpa_exp_delay.sv
// LATENCY-deep shift register carrying {valid, idx, expected} alongside the adder pipeline.
module fpa_exp_delay #(
   parameter int LATENCY = 3,
   parameter int AW      = 3,
   parameter int WIDTH   = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   input  logic [AW-1:0]    push_idx,
   input  logic [WIDTH-1:0] push_exp,
   output logic             tap_valid,
   output logic [AW-1:0]    tap_idx,
   output logic [WIDTH-1:0] tap_exp,
   output logic             pending
);

   logic [LATENCY-1:0]            vld;
   logic [LATENCY-1:0][AW-1:0]    idx_q;
   logic [LATENCY-1:0][WIDTH-1:0] exp_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld   <= '0;
         idx_q <= '0;
         exp_q <= '0;
      end else begin
         vld[0]   <= push_valid;
         idx_q[0] <= push_idx;
         exp_q[0] <= push_exp;
         for (int s = 1; s < LATENCY; s++) begin
            vld[s]   <= vld[s-1];
            idx_q[s] <= idx_q[s-1];
            exp_q[s] <= exp_q[s-1];
         end
      end
   end

   assign tap_valid = vld[LATENCY-1];
   assign tap_idx   = idx_q[LATENCY-1];
   assign tap_exp   = exp_q[LATENCY-1];
   assign pending   = |vld;

endmodule

// File: rtl/fpa_bist_sequencer.sv
// Streams {a, b, expected} vectors into a pipelined adder and checks results bit-exactly.
// Optional FPA_BIST_CAPTURE_EN adds fail_result/fail_expected capture of the first mismatch.
module fpa_bist_sequencer
   import fpa_pkg::*;
#(
   parameter int WIDTH       = DP_WIDTH,
   parameter int LATENCY     = 3,
   parameter int NUM_VECTORS = 8,
   parameter int AW          = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
   parameter int CW          = $clog2(NUM_VECTORS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [AW-1:0]      vec_addr,
   input  logic [3*WIDTH-1:0] vec_data,
   output logic [WIDTH-1:0]   op_a,
   output logic [WIDTH-1:0]   op_b,
   output logic               op_valid,
   input  logic [WIDTH-1:0]   fpa_result,
   input  logic               fpa_ready,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CW-1:0]      err_count,
   output logic [AW-1:0]      first_err_idx
`ifdef FPA_BIST_CAPTURE_EN
   ,
   output logic [WIDTH-1:0]   fail_result,
   output logic [WIDTH-1:0]   fail_expected
`endif
);

   localparam int            A_HI = 3*WIDTH - 1;
   localparam int            B_HI = 2*WIDTH - 1;
   localparam int            E_HI = WIDTH - 1;
   localparam logic [AW-1:0] LAST = AW'(NUM_VECTORS - 1);

   state_t           state, state_nxt;
   logic [AW-1:0]    idx;
   logic             clear, issue;
   logic             tap_valid, pending, mismatch;
   logic [AW-1:0]    tap_idx;
   logic [WIDTH-1:0] tap_exp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE, DONE: if (start) begin
            state_nxt = RUN;
            clear     = 1'b1;
         end
         RUN: begin
            issue = 1'b1;
            if (idx == LAST) state_nxt = DRAIN;
         end
         DRAIN: if (!pending) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // idx returns to 0 after the last issue so vec_addr never leaves the vector range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_valid <= 1'b0;
      end else begin
         op_valid <= issue;
         if (clear) begin
            idx <= '0;
         end else if (issue) begin
            idx  <= (idx == LAST) ? '0 : idx + AW'(1);
            op_a <= vec_data[A_HI -: WIDTH];
            op_b <= vec_data[B_HI -: WIDTH];
         end
      end
   end

   fpa_exp_delay #(
      .LATENCY (LATENCY),
      .AW      (AW),
      .WIDTH   (WIDTH)
   ) u_delay (
      .clk        (clk),
      .rst        (rst),
      .push_valid (issue),
      .push_idx   (idx),
      .push_exp   (vec_data[E_HI -: WIDTH]),
      .tap_valid  (tap_valid),
      .tap_idx    (tap_idx),
      .tap_exp    (tap_exp),
      .pending    (pending)
   );

   // A missing ready is as much a failure as a wrong sum.
   assign mismatch = tap_valid && (!fpa_ready || (fpa_result != tap_exp));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count     <= '0;
         first_err_idx <= '0;
      end else if (clear) begin
         err_count     <= '0;
         first_err_idx <= '0;
      end else if (mismatch) begin
         err_count <= err_count + CW'(1);
         if (err_count == '0) first_err_idx <= tap_idx;
      end
   end

`ifdef FPA_BIST_CAPTURE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_result   <= '0;
         fail_expected <= '0;
      end else if (clear) begin
         fail_result   <= '0;
         fail_expected <= '0;
      end else if (mismatch && (err_count == '0)) begin
         fail_result   <= fpa_result;
         fail_expected <= tap_exp;
      end
   end
`endif

   assign vec_addr = idx;
   assign busy     = (state == RUN) || (state == DRAIN);
   assign done     = (state == DONE);
   assign pass     = done && (err_count == '0);

endmodule

// File: doc/fpa_bist_sequencer.md
Name: fpa_bist_sequencer

Overview:
- Hardware stimulus/checker for the pipelined double-precision adder (pipeFPA32 port order: clk, rst, a, b, result, ready).
- Streams operand pairs from a vector memory into the adder at one pair per cycle.
- Delays each expected sum by the adder latency and compares it bit-exactly with the returned result.
- Reports done, pass and an error count. Used for on-chip self-test and as a synthesizable checker in simulation.

Parameters:
- WIDTH, 64, operand/result width in bits (IEEE-754 double).
- LATENCY, 3, cycles from operand launch to valid result at the adder output; must be >= 1.
- NUM_VECTORS, 8, number of vector entries to run; must be >= 1.
- AW, $clog2(NUM_VECTORS) (minimum 1), vector address width.
- CW, $clog2(NUM_VECTORS+1), error-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run; sampled only in IDLE or DONE.
- vec_addr  out  AW  vector memory address.
- vec_data  in  3*WIDTH  combinational read data {a, b, expected}, MSB first.
- op_a  out  WIDTH  adder operand 1.
- op_b  out  WIDTH  adder operand 2.
- op_valid  out  1  high when op_a/op_b carry a real vector.
- fpa_result  in  WIDTH  adder sum.
- fpa_ready  in  1  adder output-valid flag.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  CW  number of mismatching vectors in the current run.
- first_err_idx  out  AW  index of the first mismatch; valid when err_count != 0.

Behaviour:
- Reset (async, active-high): state=IDLE; vec_addr=0; op_a=op_b=0; op_valid=0; busy=done=pass=0; err_count=0; first_err_idx=0; delay line cleared.
- FSM states:
  - IDLE: on start -> RUN; idx=0; err_count and first_err_idx cleared.
  - RUN: each cycle registers op_a/op_b from vec_data[idx], asserts op_valid, pushes {valid=1, idx, expected} into the delay line, then increments idx. After idx==NUM_VECTORS-1 is issued -> DRAIN.
  - DRAIN: op_valid=0; operands hold their last value. Waits until the delay line holds no valid tag -> DONE.
  - DONE: done=1. start -> RUN (restart with counters cleared, same as from IDLE).
- vec_addr = idx, combinational from the index register. Operands appear on op_a/op_b one cycle after vec_addr presents their address.
- Delay line: LATENCY-stage shift register of {valid, idx, expected}. Stage 0 is loaded in the same edge as op_a/op_b.
- Check: each cycle the output stage is valid counts as an error if fpa_ready==0 or fpa_result != expected (bit-exact, including sign of zero and NaN payload).
  - On an error, err_count increments. If err_count was 0 before the increment, first_err_idx captures that stage's idx.
- err_count cannot overflow (CW sized for NUM_VECTORS).
- start while busy is ignored. A simultaneous start and last-result check in DRAIN is ignored; the FSM still enters DONE.
- fpa_ready high while no tag is valid is ignored; not an error.
- NUM_VECTORS=1: RUN lasts exactly one cycle.
- Reset mid-run aborts immediately: all state returns to reset values with no partial report.
- Total run, start to done: 1 + NUM_VECTORS + LATENCY cycles.

Optional Feature:
- FPA_BIST_CAPTURE_EN defined: adds outputs fail_result[WIDTH] and fail_expected[WIDTH], captured on the first mismatch with the same timing as first_err_idx, cleared by reset and by start.
- Not defined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package fpa_pkg:
  - DP_WIDTH=64.
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - Vector-field slice constants (A_MSB, B_MSB, EXP_MSB).
  - Common test constants (e.g. DP_90=64'h4056800000000000).
- Sub-module fpa_exp_delay: parameterised LATENCY-deep tag/expected shift register with async reset.

Test Plan:
- Behavioural LATENCY=3 adder; 8 vectors alternating 90+90 -> 0x4066800000000000 and 50+20 -> 0x4051800000000000 -> done at cycle 12 after start; pass=1; err_count=0.
- Same run, vector 5 expected corrupted to 0x4051800000000001 -> pass=0; err_count=1; first_err_idx=5; with FPA_BIST_CAPTURE_EN, fail_result=0x4051800000000000.
- Model holds fpa_ready=0 on the 3rd result -> err_count=1; first_err_idx=2.
- start pulsed again during RUN at cycle 4 -> ignored; single run completes with identical timing; a start in DONE launches a second run with counters cleared.
- rst asserted at cycle 6 of RUN -> all outputs 0 within the same cycle (async); a subsequent start yields a clean pass.
- NUM_VECTORS=1, LATENCY=1, vector 1.0+1.0 (0x3FF0000000000000) expected 0x4000000000000000 -> done after 3 cycles; pass=1.
